fetch_queue: RTL and testbench

Instruction fetch stage directly upstream of the CPU decode logic. It owns the PC and issues word fetches to instruction memory. Returned instructions are buffered, tagged with their PC, in a small FIFO that feeds decode through a valid/ready handshake. A redirect input from execute (branch/jump) flushes wrong-path state and restarts fetch at a new PC.

---
 rtl/fetch_queue_if.sv | 39 +++
 rtl/fetch_queue.sv | 172 +++++++++++++++++
 tb/tb_fetch_queue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: the instruction-memory request/response pair,
// the decode valid/ready handshake with its PC tag, and the redirect input
// from execute. The master modport is the fetch queue itself; the slave
// modport is the surrounding environment (memory, decode, execute).
interface fetch_queue_if;
    logic [31:0] inst_addr;
    logic        inst_req;
    logic [31:0] instr;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output inst_addr,
        output inst_req,
        input  instr,
        output dec_valid,
        output dec_instr,
        output dec_pc,
        input  dec_ready,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  inst_addr,
        input  inst_req,
        output instr,
        input  dec_valid,
        input  dec_instr,
        input  dec_pc,
        output dec_ready,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage. Owns the PC, issues one word fetch per cycle to a
// fixed one-cycle-latency instruction memory, and buffers returned words
// (tagged with their fetch PC) in a small FIFO that feeds decode.
// A redirect flushes the FIFO, discards any wrong-path response and restarts
// fetch at the new (word-aligned) PC after a single idle cycle.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW:0]   ROOM_LIMIT = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    // Architectural state
    state_t        state_r;
    logic [31:0]   pc_r;
    logic [31:0]   req_pc_r;
    logic          inflight_r;
    logic          drop_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [31:0]   instr_mem_r [DEPTH];
    logic [31:0]   pc_mem_r    [DEPTH];

    // Combinational control
    state_t        state_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          dec_valid_s;
    logic          room_s;
    logic [CW:0]   occupancy_s;
    logic [31:0]   redirect_pc_s;

    // The low two address bits of a redirect target are forced to zero so
    // every fetch stays word aligned.
    assign redirect_pc_s = bus.redirect_pc & 32'hFFFF_FFFC;

    // Handshake qualifiers and room check. Occupancy counts the response
    // already in flight and credits a pop happening this cycle, so the issue
    // rule never lets a push land on a full queue.
    always_comb begin
        dec_valid_s = (count_r != {CW{1'b0}}) && !bus.redirect;
        pop_s       = dec_valid_s && bus.dec_ready;
        push_s      = inflight_r && !drop_r && !bus.redirect;
        occupancy_s = {1'b0, count_r}
                    + {{CW{1'b0}}, inflight_r}
                    - {{CW{1'b0}}, pop_s};
        room_s      = (occupancy_s < ROOM_LIMIT);
    end

    // Next-state and issue decision; a redirect overrides every state.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                state_s = ST_FETCH;
                issue_s = !bus.redirect && room_s;
            end
            ST_REDIR: begin
                state_s = ST_FETCH;
            end
            default: begin
                state_s = ST_BOOT;
            end
        endcase
        if (bus.redirect) begin
            state_s = ST_REDIR;
        end else begin
            state_s = state_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // PC, in-flight tracking and the one-cycle wrong-path drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            req_pc_r   <= RESET_PC;
            inflight_r <= 1'b0;
            drop_r     <= 1'b0;
        end else if (bus.redirect) begin
            pc_r       <= redirect_pc_s;
            inflight_r <= 1'b0;
            drop_r     <= inflight_r;
        end else if (issue_s) begin
            pc_r       <= pc_r + 32'd4;
            req_pc_r   <= pc_r;
            inflight_r <= 1'b1;
            drop_r     <= 1'b0;
        end else begin
            inflight_r <= 1'b0;
            drop_r     <= 1'b0;
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk) begin
        if (reset || bus.redirect) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero until the first
    // instruction arrives. Redirect leaves stale contents (masked by valid).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]    <= 32'h0000_0000;
            end
        end else if (push_s) begin
            instr_mem_r[tail_r] <= bus.instr;
            pc_mem_r[tail_r]    <= req_pc_r;
        end else begin
            instr_mem_r[tail_r] <= instr_mem_r[tail_r];
            pc_mem_r[tail_r]    <= pc_mem_r[tail_r];
        end
    end

    assign bus.inst_addr = pc_r;
    assign bus.inst_req  = issue_s;
    assign bus.dec_valid = dec_valid_s;
    assign bus.dec_instr = instr_mem_r[head_r];
    assign bus.dec_pc    = pc_mem_r[head_r];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a transaction-level model (PC, pending response,
// queue of {pc, instr}) predicts the outputs every cycle under directed and
// randomized reset / redirect / dec_ready stimulus.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_init = 1'b0;
    logic [31:0] m_pc;
    int          m_idle;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_head_zero;
    logic [31:0] q_pc [$];
    logic [31:0] q_in [$];

    // Memory-side capture of the request made in the current cycle
    logic        cap_req  = 1'b0;
    logic [31:0] cap_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic dr);
        bit e_valid;
        bit e_pop;
        bit e_req;
        int occ;
        @(negedge clk);
        reset           = r;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.dec_ready   = dr;
        bus.instr       = cap_req ? mem_word(cap_addr) : $urandom;
        #1;
        e_valid = m_init && (q_pc.size() != 0) && !rd;
        e_pop   = e_valid && dr;
        occ     = q_pc.size() + (m_pend ? 1 : 0) - (e_pop ? 1 : 0);
        e_req   = m_init && (m_idle == 0) && !rd && (occ < DEPTH);
        if (m_init) begin
            check("dec_valid", {31'b0, bus.dec_valid}, {31'b0, e_valid});
            check("inst_req", {31'b0, bus.inst_req}, {31'b0, e_req});
            check("inst_addr", bus.inst_addr, m_pc);
            if (e_valid) begin
                check("dec_pc", bus.dec_pc, q_pc[0]);
                check("dec_instr", bus.dec_instr, q_in[0]);
            end else if (m_head_zero) begin
                check("dec_pc_rst", bus.dec_pc, 32'h0);
                check("dec_instr_rst", bus.dec_instr, 32'h0);
            end
        end
        cap_req  = bus.inst_req;
        cap_addr = bus.inst_addr;
        @(posedge clk);
        if (r) begin
            m_init      = 1'b1;
            m_pc        = RESET_PC;
            m_idle      = 1;
            m_pend      = 1'b0;
            m_head_zero = 1'b1;
            q_pc.delete();
            q_in.delete();
        end else if (m_init && rd) begin
            q_pc.delete();
            q_in.delete();
            m_pend = 1'b0;
            m_pc   = {rpc[31:2], 2'b00};
            m_idle = 1;
        end else if (m_init) begin
            if (m_pend) begin
                q_pc.push_back(m_pend_pc);
                q_in.push_back(mem_word(m_pend_pc));
                m_head_zero = 1'b0;
            end
            if (e_pop) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            m_pend    = e_req;
            m_pend_pc = m_pc;
            if (e_req) m_pc = m_pc + 32'd4;
            if (m_idle > 0) m_idle--;
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.dec_ready   = 1'b0;
        bus.instr       = 32'h0;

        // Streaming from reset with decode always ready
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Decode stalled from reset: queue fills, then drains with re-issue
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Full queue, one pop to put 0x10 in flight, then redirect to 0x40
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Misaligned redirect target
        step(1'b0, 1'b1, 32'h0000_0043, 1'b1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Back-to-back redirects: only the second path survives
        step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset mid-stream with a full queue and a request in flight
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect while still in BOOT after reset release
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0800, 1'b1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom,
                 $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
